// File: rtl/serial_frame_rx_if.sv
// Output stream of the serial frame receiver: word + valid/ready handshake
// plus error status. Member names are from the receiver's point of view.
interface serial_frame_rx_if #(
    parameter int BIT_WIDTH = 8
);
    logic [BIT_WIDTH-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 parity_err_o;
    logic                 frame_err_o;
    logic                 overrun_o;

    // Receiver side: produces words and status, consumes ready.
    modport master (
        output data_o, valid_o, parity_err_o, frame_err_o, overrun_o,
        input  ready_i
    );

    // Consumer side.
    modport slave (
        input  data_o, valid_o, parity_err_o, frame_err_o, overrun_o,
        output ready_i
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start 0, BIT_WIDTH data bits, optional even parity,
// stop 1. Samples the line only on en_i strobes, presents good words on a
// valid/ready stream and flags parity, framing and overrun conditions.
module serial_frame_rx #(
    parameter int BIT_WIDTH = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 n_rst_i,
    input  logic                 en_i,
    input  logic                 serial_i,
    input  logic                 msb_first_i,
    serial_frame_rx_if.master    bus
);
    localparam int CNT_W = $clog2(BIT_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0] shift_q, shift_d;
    logic                 msb_q, msb_d;       // bit order latched at start bit
    logic                 par_bad_q, par_bad_d;
    logic [BIT_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            msb_q     <= 1'b0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            msb_q     <= msb_d;
            par_bad_q <= par_bad_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    // Next state: handshake and pulse clearing every cycle, frame FSM on strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        msb_d     = msb_q;
        par_bad_d = par_bad_q;
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = ovr_q;

        if (valid_q && bus.ready_i)
            valid_d = 1'b0;

        if (en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (!serial_i) begin
                        state_d   = S_DATA;
                        cnt_d     = '0;
                        msb_d     = msb_first_i;
                        par_bad_d = 1'b0;
                    end
                end
                S_DATA: begin
                    if (msb_q)
                        shift_d = {shift_q[BIT_WIDTH-2:0], serial_i};
                    else
                        shift_d = {serial_i, shift_q[BIT_WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIT_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    // Even parity: XOR over data and parity bit must be 0.
                    par_bad_d = (^shift_q) ^ serial_i;
                    state_d   = S_STOP;
                end
                S_STOP: begin
                    if (serial_i) begin
                        state_d = S_IDLE;
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else if (!valid_q || bus.ready_i) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
                S_BREAK: begin
                    // Wait for the line to return high so a held-low line
                    // cannot masquerade as a start bit.
                    if (serial_i)
                        state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.data_o       = data_q;
    assign bus.valid_o      = valid_q;
    assign bus.parity_err_o = perr_q;
    assign bus.frame_err_o  = ferr_q;
    assign bus.overrun_o    = ovr_q;

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the serial output of the 8-bit shift register stage.
- Detects framed serial words on a bit-strobe timebase and deserialises them into parallel words.
- Frame format: start bit 0, BIT_WIDTH data bits, optional even-parity bit, stop bit 1.
- Presents each good word on a valid/ready interface and reports parity, framing and overrun errors.

Parameters:
- BIT_WIDTH, 8, data bits per frame (>=2).
- PARITY_EN, 1, 1 = even-parity bit present between last data bit and stop bit; 0 = no parity bit.

Ports:
- clk_i  in  1  clock, rising edge.
- n_rst_i  in  1  reset, synchronous, active-low.
- en_i  in  1  bit strobe; serial_i is sampled only on clock edges where en_i=1.
- serial_i  in  1  serial line; idles high.
- msb_first_i  in  1  1 = first data bit is the MSB; 0 = first data bit is the LSB.
- ready_i  in  1  consumer accepts data_o when valid_o=1 and ready_i=1.
- data_o  out  BIT_WIDTH  received word.
- valid_o  out  1  data_o holds an unconsumed word.
- parity_err_o  out  1  one-cycle pulse: parity mismatch, word discarded.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled as 0, word discarded.
- overrun_o  out  1  sticky: a good word was dropped because valid_o=1 and ready_i=0.

Behaviour:
- Reset (n_rst_i=0 at a rising edge) overrides everything, including a frame in progress:
  - state=IDLE, bit counter=0, shift register=0.
  - data_o=0, valid_o=0, parity_err_o=0, frame_err_o=0, overrun_o=0.
- States: IDLE, DATA, PARITY, STOP, BREAK. Transitions happen only on en_i=1 edges. With en_i=0, state, counter and shift register hold.
- Handshake logic and error-pulse clearing run every cycle, independent of en_i.
- IDLE: sampled 0 -> DATA, counter=0, latch msb_first_i for the whole frame. Sampled 1 -> stay in IDLE.
- DATA: each sample loads one bit into the shift register.
  - MSB-first: shift left, new bit enters at bit 0.
  - LSB-first: shift right, new bit enters at bit BIT_WIDTH-1.
  - Counter is $clog2(BIT_WIDTH) bits wide and increments per sample.
  - After the BIT_WIDTH-th sample (counter==BIT_WIDTH-1): go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: sample bit p and store the result of XOR(data bits, p) for the stop-bit decision (0 = good). -> STOP.
- STOP, sampled 1:
  - Stored parity mismatch -> parity_err_o=1 for one cycle, word discarded.
  - Parity good and (valid_o=0, or ready_i=1 on the same edge) -> data_o<=word, valid_o<=1.
  - Parity good, valid_o=1 and ready_i=0 -> word dropped, data_o unchanged, overrun_o<=1.
  - Next state IDLE in all three cases.
- STOP, sampled 0 -> frame_err_o=1 for one cycle, word discarded (no overrun update), -> BREAK.
- BREAK: stay until a 1 is sampled, then -> IDLE. A line held low therefore never starts a false frame.
- Latency: valid_o=1 is visible in the cycle after the stop-bit sample edge.
- Handshake:
  - valid_o falls on the edge where valid_o=1 and ready_i=1, unless a new word loads on that same edge; then valid_o stays 1 and data_o takes the new word.
  - data_o is stable while valid_o=1.
  - ready_i is ignored when valid_o=0.
- overrun_o clears only on reset.
- Error pulses last one clk_i cycle regardless of en_i.
- The next start bit may be sampled on the en_i edge immediately following the stop bit. There is no mandatory idle gap.

Test Plan:
- Reset mid-frame: reset after 3 data bits, then send a full frame of 0xA5 MSB-first with PARITY_EN=1 (parity bit 0), ready_i=1 -> exactly one word 0xA5. No error pulses. No residue from the aborted frame.
- Bit order: send 0x3C MSB-first, then 0x3C LSB-first, back-to-back with no idle bits -> data_o 0x3C then 0x3C. Swap msb_first_i mid-frame -> it has no effect on the frame in progress.
- Parity: send 0x07 with parity bit 0 (correct value is 1) -> parity_err_o single-cycle pulse, valid_o stays 0. Then send 0x07 with parity bit 1 -> valid_o=1, data_o=0x07.
- Framing: send 0x55 with stop bit 0 and hold line low 5 strobes -> one frame_err_o pulse, no start detected while low. Line returns to 1, then frame 0x12 -> data_o=0x12.
- Overrun and simultaneous events:
  - ready_i=0, send 0x11 then 0x22 -> data_o=0x11, overrun_o=1 sticky.
  - Reset, send 0x33, then assert ready_i on the same edge the 0x44 stop bit is sampled -> data_o=0x44, valid_o stays 1, overrun_o=0.
- Strobe gating: en_i asserted every 4th cycle with random stall gaps, frame 0xC3 -> same result as continuous en_i. State holds during en_i=0.
